swg_buffer_scheduler: RTL
=========================

Name: swg_buffer_scheduler

Overview:
- Sequences one sliding-window-generator frame through a dual-port cyclic buffer.
- Accepts input-stream elements and issues buffer writes. Issues buffer reads in the order the loop controller dictates, pulsing advance once per read.
- Guarantees reads never pass unwritten data and writes never overwrite data still needed.
- Sits between the input AXI-stream, the addressable cyclic buffer (1-cycle read latency) and the loop controller. Carries no data itself.

Parameters:
BUF_DEPTH, 16, buffer depth in elements; power of two not required; >=2
IN_ELEMS, 64, input elements written per frame
OUT_ELEMS, 144, reads/output elements issued per frame
INCR_BITWIDTH, 8, width of signed addr_incr/tail_incr; |incr| < BUF_DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input element available
in_ready  out  1  input element accepted when in_valid&in_ready
out_valid  out  1  buffer data_out holds a valid output element
out_ready  in  1  downstream accepts when out_valid&out_ready
addr_incr  in  INCR_BITWIDTH  signed head increment from controller, applied per read
tail_incr  in  INCR_BITWIDTH  signed tail increment from controller, applied per read
advance  out  1  step controller; equals read_enable
write_enable  out  1  buffer write strobe; equals in_valid&in_ready
write_addr  out  $clog2(BUF_DEPTH)  physical write address
read_enable  out  1  buffer read strobe
read_addr  out  $clog2(BUF_DEPTH)  physical read address
frame_done  out  1  one-cycle pulse after last output accepted

Behaviour:
- Logical counters, width $clog2(max(IN_ELEMS,OUT_ELEMS)+BUF_DEPTH)+2, signed:
  - Wr_cnt: elements written.
  - Head: logical index of next read.
  - Tail: oldest element still needed.
  - Rd_cnt: reads issued.
- Physical pointers Wp and Rp track Wr_cnt and Head modulo BUF_DEPTH.
- Wrap rule for Rp: sum = Rp + sign-extended addr_incr; if sum >= BUF_DEPTH subtract BUF_DEPTH; if sum < 0 add BUF_DEPTH.
- Reset (rst_n=0 at posedge): all counters/pointers 0, state S_RUN, out_valid=0, frame_done=0. Mid-frame reset discards the frame immediately; in_ready=0 during the reset cycle.
- in_ready = (state==S_RUN) & (Wr_cnt < IN_ELEMS) & (Wr_cnt - Tail < BUF_DEPTH).
  - write_addr = Wp. On write: Wp wraps BUF_DEPTH-1 -> 0; Wr_cnt += 1.
- can_read = (state!=S_DONE) & (Rd_cnt < OUT_ELEMS) & (Head < Wr_cnt) & (!out_valid | out_ready).
  - read_enable = advance = can_read; read_addr = Rp.
  - On read: Head += addr_incr, Tail += tail_incr, Rp wraps as above, Rd_cnt += 1.
- A write and a read in the same cycle are both performed. The write-side fullness check uses pre-update Tail. The read-side availability check uses pre-update Wr_cnt, so no same-cycle bypass.
- out_valid: set the cycle after read_enable. Cleared on out_ready when no new read is issued. Held while out_ready=0; the buffer output register holds because read_enable stays 0.
- States:
  - S_RUN -> S_DRAIN when Wr_cnt reaches IN_ELEMS.
  - S_DRAIN -> S_DONE when Rd_cnt reaches OUT_ELEMS.
  - S_DONE: wait for out_valid=0, or the out_valid&out_ready handshake. Then pulse frame_done for 1 cycle, clear all counters/pointers, return to S_RUN.
  - The controller's final increments are discarded; the controller self-wraps to its start state.
- Deadlock guard: if Head >= Wr_cnt and Wr_cnt - Tail >= BUF_DEPTH simultaneously, the configuration is illegal. Behaviour is undefined; assertion fires in simulation.
- Latency: first read no earlier than the cycle after the first write; first out_valid 1 cycle after that read.

Optional Feature:
- Macro SWG_SCHED_PERF_EN.
- Defined: adds outputs stall_in_cnt and stall_out_cnt (32 bits each, saturating, cleared by reset and on frame_done).
  - stall_in_cnt increments each cycle with in_valid & !in_ready while state==S_RUN.
  - stall_out_cnt increments each cycle with out_valid & !out_ready.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- 1D, K=3, stride 1: BUF_DEPTH=4, IN_ELEMS=6, OUT_ELEMS=12, addr_incr per read +1,+1,-1 repeated, tail_incr 0,0,+1; always-valid input, always-ready output -> read_addr sequence 0,1,2,1,2,3,2,3,0,3,0,1; 12 out_valid beats; one frame_done.
- Same config, out_ready toggled 1-of-3 cycles -> read_enable never asserted while out_valid&!out_ready; output order unchanged; no read beyond Wr_cnt.
- Input starved (in_valid low 10 cycles after 2 writes) -> reads stop at Head=2, out_valid drops, resume on next write.
- Backpressure fill: out_ready=0 from reset, BUF_DEPTH=4 -> exactly 4 writes accepted before in_ready=0 (Tail=0), then held.
- Reset asserted mid-frame after 5 reads -> next cycle all pointers 0, out_valid=0; full frame afterwards matches first test.
- Two back-to-back frames -> frame_done pulses twice; second frame read_addr sequence identical to first; with SWG_SCHED_PERF_EN, stall_out_cnt equals count of out_valid&!out_ready cycles.

Source files
------------

// File: rtl/swg_buffer_scheduler.sv
// swg_buffer_scheduler: sequences one sliding-window-generator frame through a
// dual-port cyclic buffer. Issues buffer writes for accepted input elements and
// buffer reads in the order dictated by the loop controller. Reads never pass
// unwritten data and writes never overwrite data a later read still needs.
// The block carries no data itself.
//
// Optional feature: define SWG_SCHED_PERF_EN to add the saturating
// stall_in_cnt / stall_out_cnt performance counters.
module swg_buffer_scheduler #(
  parameter int BUF_DEPTH     = 16,
  parameter int IN_ELEMS      = 64,
  parameter int OUT_ELEMS     = 144,
  parameter int INCR_BITWIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic signed [INCR_BITWIDTH-1:0] addr_incr,
  input  logic signed [INCR_BITWIDTH-1:0] tail_incr,
  output logic                            advance,
  output logic                            write_enable,
  output logic [$clog2(BUF_DEPTH)-1:0]    write_addr,
  output logic                            read_enable,
  output logic [$clog2(BUF_DEPTH)-1:0]    read_addr,
  output logic                            frame_done
`ifdef SWG_SCHED_PERF_EN
  ,
  output logic [31:0]                     stall_in_cnt,
  output logic [31:0]                     stall_out_cnt
`endif
);

  localparam int AW        = $clog2(BUF_DEPTH);
  localparam int MAX_ELEMS = (IN_ELEMS > OUT_ELEMS) ? IN_ELEMS : OUT_ELEMS;
  localparam int CNT_W     = $clog2(MAX_ELEMS + BUF_DEPTH) + 2;
  // Physical-pointer sum needs room for [-(BUF_DEPTH-1), 2*BUF_DEPTH-2].
  localparam int PW        = AW + 2;

  localparam logic signed [CNT_W-1:0] IN_C    = CNT_W'(IN_ELEMS);
  localparam logic signed [CNT_W-1:0] OUT_C   = CNT_W'(OUT_ELEMS);
  localparam logic signed [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic signed [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic signed [PW-1:0]    DEPTH_P = PW'(BUF_DEPTH);
  localparam logic [AW-1:0]           LAST_A  = AW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Logical counters (signed so controller increments may move head/tail back).
  logic signed [CNT_W-1:0] wr_cnt, head, tail, rd_cnt;
  logic signed [CNT_W-1:0] fill;
  logic [AW-1:0]           wp, rp, rp_next;
  logic signed [PW-1:0]    rp_sum, rp_fix;
  logic                    can_read;
  logic                    done_fire;

  // Elements held in the buffer that are still needed by some future read.
  assign fill = wr_cnt - tail;

  // Handshake qualifiers; both are forced low while reset is asserted so a
  // mid-frame reset drops the frame in the same cycle.
  assign in_ready = rst_n && (state == S_RUN) && (wr_cnt < IN_C) && (fill < DEPTH_C);
  assign can_read = rst_n && (state != S_DONE) && (rd_cnt < OUT_C) && (head < wr_cnt)
                    && (!out_valid || out_ready);

  assign write_enable = in_valid && in_ready;
  assign write_addr   = wp;
  assign read_enable  = can_read;
  assign advance      = can_read;
  assign read_addr    = rp;

  // Physical read pointer follows head modulo BUF_DEPTH; |addr_incr| < BUF_DEPTH
  // so a single correction in either direction is enough.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rp_sum = $signed({{(PW - AW){1'b0}}, rp}) + PW'(addr_incr);
    rp_fix = rp_sum;
    if (rp_sum >= DEPTH_P) begin
      rp_fix = rp_sum - DEPTH_P;
    end else if (rp_sum[PW-1]) begin
      rp_fix = rp_sum + DEPTH_P;
    end
    rp_next = rp_fix[AW-1:0];
  end

  // Frame sequencing: run while input is pending, drain remaining reads, then
  // wait for the last output beat to leave before closing the frame.
  always_comb begin
    state_n   = state;
    done_fire = 1'b0;
    case (state)
      S_RUN:   if (wr_cnt == IN_C) state_n = S_DRAIN;
      S_DRAIN: if (rd_cnt == OUT_C) state_n = S_DONE;
      S_DONE: begin
        if (!out_valid || out_ready) begin
          done_fire = 1'b1;
          state_n   = S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  // State, counters, pointers and the output-valid flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state      <= S_RUN;
      wr_cnt     <= '0;
      head       <= '0;
      tail       <= '0;
      rd_cnt     <= '0;
      wp         <= '0;
      rp         <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= done_fire;
      if (done_fire) begin
        // Controller's final increments are discarded; start the next frame clean.
        wr_cnt    <= '0;
        head      <= '0;
        tail      <= '0;
        rd_cnt    <= '0;
        wp        <= '0;
        rp        <= '0;
        out_valid <= 1'b0;
      end else begin
        if (write_enable) begin
          wp     <= (wp == LAST_A) ? '0 : wp + AW'(1);
          wr_cnt <= wr_cnt + ONE_C;
        end
        if (read_enable) begin
          head   <= head + CNT_W'(addr_incr);
          tail   <= tail + CNT_W'(tail_incr);
          rp     <= rp_next;
          rd_cnt <= rd_cnt + ONE_C;
        end
        // Buffer output register is valid one cycle after a read and holds
        // under backpressure because no new read is issued.
        if (read_enable) begin
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Illegal configuration: nothing left to read yet no room to write.
  assert property (@(posedge clk) disable iff (!rst_n)
    ((state != S_DONE) && (rd_cnt < OUT_C)) |-> !((head >= wr_cnt) && (fill >= DEPTH_C)));

`ifdef SWG_SCHED_PERF_EN
  // Saturating stall counters, cleared by reset and when a frame closes.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_done) begin
      stall_in_cnt  <= '0;
      stall_out_cnt <= '0;
    end else begin
      if ((state == S_RUN) && in_valid && !in_ready && (stall_in_cnt != '1)) begin
        stall_in_cnt <= stall_in_cnt + 32'd1;
      end
      if (out_valid && !out_ready && (stall_out_cnt != '1)) begin
        stall_out_cnt <= stall_out_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
